// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: sequential instruction fetch into a prefetch FIFO.
// Optional debug register enabled by defining FETCH_DEBUG_EN.
module cpu_fetch_unit #(
    parameter int                 DATA_W     = 16,
    parameter int                 ADDR_W     = 16,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
    input  logic              wire_clock,
    input  logic              wire_reset_n,
    output logic [ADDR_W-1:0] bus_RAM_ADDRESS,
    input  logic [DATA_W-1:0] bus_RAM_DATA_OUT,
    output logic              wire_RW,
    output logic [DATA_W-1:0] bus_RAM_DATA_IN,
    input  logic              wire_redirect,
    input  logic [ADDR_W-1:0] bus_redirect_pc,
    output logic              wire_instr_valid,
    output logic [DATA_W-1:0] bus_instr,
    output logic [ADDR_W-1:0] bus_instr_pc,
    input  logic              wire_instr_ready,
    output logic [DATA_W-1:0] data_debug
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic              room;
    logic              issue;
    logic              push;
    logic              pop;

    assign wire_RW          = 1'b0;
    assign bus_RAM_DATA_IN  = '0;
    assign room             = count < CNT_W'(FIFO_DEPTH);
    assign wire_instr_valid = count != '0;
    assign bus_instr        = fifo_data[rd_ptr];
    assign bus_instr_pc     = fifo_pc[rd_ptr];
    assign pop = wire_instr_valid && wire_instr_ready && !wire_redirect;

    // Next-state and fetch strobes; redirect cancels any issue or push.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        case (state)
            S_ISSUE: begin
                if (room) begin
                    issue      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                push       = 1'b1;
                state_next = S_ISSUE;
            end
            default: begin
                state_next = S_ISSUE;
            end
        endcase
        if (wire_redirect) begin
            issue      = 1'b0;
            push       = 1'b0;
            state_next = S_ISSUE;
        end
    end

    // FSM state register.
    always_ff @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) begin
            state <= S_ISSUE;
        end else begin
            state <= state_next;
        end
    end

    // Program counter and registered RAM address.
    always_ff @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) begin
            pc              <= RESET_PC;
            bus_RAM_ADDRESS <= RESET_PC;
        end else if (wire_redirect) begin
            pc <= bus_redirect_pc;
        end else begin
            if (issue) begin
                bus_RAM_ADDRESS <= pc;
            end
            if (push) begin
                pc <= pc + ADDR_W'(1);
            end
        end
    end

    // FIFO pointers and occupancy; redirect empties the buffer.
    always_ff @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (wire_redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: captured word and the address it came from.
    always_ff @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (push) begin
            fifo_data[wr_ptr] <= bus_RAM_DATA_OUT;
            fifo_pc[wr_ptr]   <= pc;
        end
    end

`ifdef FETCH_DEBUG_EN
    // Last word pushed; survives redirect, cleared only by reset.
    always_ff @(posedge wire_clock or negedge wire_reset_n) begin
        if (!wire_reset_n) begin
            data_debug <= '0;
        end else if (push) begin
            data_debug <= bus_RAM_DATA_OUT;
        end
    end
`else
    assign data_debug = '0;
`endif

endmodule

// File: doc/cpu_fetch_unit.md
# cpu_fetch_unit

Parametrised instruction-fetch front end for the soft CPU. It reads instruction words from the shared synchronous RAM with a sequential program counter. Fetched words and their addresses are buffered in a small prefetch FIFO, then handed to the decode stage over a valid/ready handshake. A branch redirect input flushes the buffer and restarts fetch at a new address.

## Interface
- DATA_W, 16, instruction/RAM data width
- ADDR_W, 16, RAM address and PC width
- FIFO_DEPTH, 4, prefetch entries; power of two, >= 2
- RESET_PC, 0, PC loaded on reset
- wire_clock  in  1  sole clock, rising edge
- wire_reset_n  in  1  asynchronous, active-low reset
- bus_RAM_ADDRESS  out  ADDR_W  registered RAM address
- bus_RAM_DATA_OUT  in  DATA_W  RAM read data (data out of RAM)
- wire_RW  out  1  RAM write enable; tied 0 (read only)
- bus_RAM_DATA_IN  out  DATA_W  RAM write data; tied 0
- wire_redirect  in  1  one-cycle pulse: flush and refetch
- bus_redirect_pc  in  ADDR_W  new PC, sampled when wire_redirect=1
- wire_instr_valid  out  1  FIFO head valid
- bus_instr  out  DATA_W  FIFO head instruction
- bus_instr_pc  out  ADDR_W  address of bus_instr
- wire_instr_ready  in  1  decode accepts head this cycle
- data_debug  out  DATA_W  debug word; see Configuration

## Operation
- RAM model: the address registered at edge N is sampled by the RAM at edge N+1. Data is valid before edge N+2.
- FSM states and transitions:
  - S_ISSUE: if count < FIFO_DEPTH, bus_RAM_ADDRESS <= pc and go to S_WAIT. Otherwise hold in S_ISSUE.
  - S_WAIT: go to S_CAPTURE unconditionally.
  - S_CAPTURE: push {pc, bus_RAM_DATA_OUT}, pc <= pc + 1, go to S_ISSUE.
- Only one fetch is outstanding at a time. The room check in S_ISSUE guarantees a FIFO slot in S_CAPTURE, so a push never overflows.
- PC arithmetic is modulo 2^ADDR_W. The PC after all-ones is 0; no flag is raised.
- FIFO control:
  - Pop occurs when wire_instr_valid && wire_instr_ready.
  - A push and a pop in the same cycle leave count unchanged.
  - count has width log2(FIFO_DEPTH)+1.
  - wire_instr_valid = (count != 0).
  - bus_instr and bus_instr_pc are combinational from the head entry.
- Redirect has priority over everything, in any state:
  - count := 0, read and write pointers := 0, pc := bus_redirect_pc, state := S_ISSUE.
  - Any same-cycle pop or push is discarded, including a fetch in flight in S_WAIT or S_CAPTURE.
- wire_instr_ready while wire_instr_valid=0 has no effect.
- Reset values (asynchronous, on wire_reset_n=0):
  - state S_ISSUE, pc RESET_PC, bus_RAM_ADDRESS RESET_PC.
  - count 0, pointers 0, all FIFO storage 0.
  - wire_instr_valid 0, bus_instr 0, bus_instr_pc 0.
  - wire_RW 0, bus_RAM_DATA_IN 0, data_debug 0.
- Reset asserted mid-fetch aborts the fetch; nothing is pushed.

## Timing
- First edge after reset release (E1): address RESET_PC issued.
- E3: word captured. wire_instr_valid=1 after E3.
- Steady-state throughput: one instruction per 3 cycles while the FIFO is not full.
- Redirect at edge R: new address issued at R+1, head valid after R+3.
- A full FIFO stalls in S_ISSUE. After a pop at edge P, the next issue is at P+1.

## Configuration
- FETCH_DEBUG_EN defined: data_debug is a register holding the last instruction pushed into the FIFO. It resets to 0 and is not cleared by redirect.
- FETCH_DEBUG_EN undefined: data_debug is constant 0 and no register is inferred.

## Test plan
- Reset then run with ready=1 and RAM[0..3]=0x1111,0x2222,0x3333,0x4444 -> instructions appear in order with pc 0,1,2,3. First valid appears after the 3rd edge following reset release.
- ready=0, FIFO_DEPTH=4 -> exactly 4 entries, addresses 0..3. bus_RAM_ADDRESS holds 3 and the FSM stays in S_ISSUE. One pop -> address 4 is issued on the next edge.
- Redirect to 0x0100 while in S_WAIT with 2 entries queued -> valid drops next cycle, stale word not pushed, next head is RAM[0x0100] with pc 0x0100.
- Redirect in the same cycle as a pop with count=3 -> count=0 afterwards. No entry is lost or duplicated after refetch.
- RESET_PC=0xFFFF -> pcs captured are 0xFFFF then 0x0000.
- With FETCH_DEBUG_EN, push 0xABCD -> data_debug=0xABCD. Without the macro, data_debug stays 0x0000 throughout.
